cnn_core_mac_pipe: RTL
======================

CNN_CORE_MAC_PIPE -- requirements
Module: cnn_core_mac_pipe

Interface
REQ-001 SHALL have parameter DIN0_W, default 16, width of signed operand din0.
REQ-002 SHALL have parameter DIN1_W, default 6, width of unsigned operand din1.
REQ-003 SHALL have parameter NUM_STAGE, default 3, multiplier pipeline depth; legal range 1..4.
REQ-004 SHALL have parameter ACC_W, default 32, accumulator/result width; ACC_W >= DIN0_W+DIN1_W.
REQ-005 SHALL have port ap_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port ap_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  block accepts beat when in_valid&&in_ready.
REQ-009 SHALL have port din0  input  DIN0_W  signed operand.
REQ-010 SHALL have port din1  input  DIN1_W  unsigned operand.
REQ-011 SHALL have port in_last  input  1  final beat of accumulation group.
REQ-012 SHALL have port mode  input  1  0 = multiply-only, 1 = accumulate; sampled per beat.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port out_data  output  ACC_W  signed result.
REQ-016 SHALL have port out_sat  output  1  saturation occurred within the reported group.

Function
REQ-017 Product SHALL be din0 (signed) times {1'b0,din1}, P_W = DIN0_W+DIN1_W bits signed, sign-extended to ACC_W.
REQ-018 Multiplier SHALL be registered NUM_STAGE times; beat, mode, in_last travel alongside in valid-tagged stage registers.
REQ-019 Latency SHALL be NUM_STAGE+1 cycles from acceptance to out_valid, absent stall; throughput one beat/cycle.
REQ-020 Stall SHALL be global: ce = !out_valid || out_ready; in_ready = ce; all stage and output registers hold when ce=0.
REQ-021 Mode 0 beat SHALL produce one result equal to the product; in_last ignored; accumulator untouched.
REQ-022 Mode 1 beats SHALL sum into the accumulator; first beat of a group loads the product instead of adding.
REQ-023 Mode 1 SHALL emit only on in_last beat: out_data = final sum, then accumulator group restarts.
REQ-024 Each addition SHALL saturate to signed ACC_W max/min; out_sat = OR of saturation events in the group; mode 0 out_sat=0.
REQ-025 Once saturated, later additions SHALL continue from the clamped value.
REQ-026 Mode changing mid-group SHALL be a protocol error; behaviour defined only as: mode 0 beat emits its product, open group continues.
REQ-027 out_valid, out_data, out_sat SHALL remain stable while out_valid && !out_ready.
REQ-028 Results SHALL leave in acceptance order; no beat lost or duplicated under any out_ready pattern.

Reset
REQ-029 ap_rst assertion SHALL immediately clear out_valid, out_sat, out_data, all stage valid flags, accumulator and group-open flag to 0.
REQ-030 in_ready SHALL be 1 during and after reset (out_valid=0); beats offered during reset are dropped.
REQ-031 Reset mid-group SHALL discard the partial sum; next accepted beat starts a new group.

Structure
REQ-032 Package cnn_core_mac_pkg SHALL hold mode encodings (MODE_MUL=0, MODE_ACC=1) and saturation max/min constant functions of ACC_W.
REQ-033 Sub-module cnn_core_mul_su_pipe SHALL implement the NUM_STAGE signed×unsigned multiplier with ce input; accumulator, control in top.

Verification (DIN0_W=16, DIN1_W=6, NUM_STAGE=3, ACC_W=24)
REQ-034 Mode 0, din0=-3, din1=63 -> out_data=-189 (0xFFFF43), out_valid exactly 4 cycles after accept, out_sat=0.
REQ-035 Mode 1, beats (100,2),(-50,3),(7,1),(0,63,last) -> single result 57, out_sat=0.
REQ-036 Mode 1, five beats (32767,63), last on fifth -> out_data=8388607, out_sat=1; next group (1,1,last) -> 1, out_sat=0.
REQ-037 Din1 signedness: din0=-32768, din1=63 mode 0 -> -2064384 (din1 not treated as -1).
REQ-038 Backpressure: 6 mode-0 beats back-to-back, out_ready low 5 cycles mid-stream -> in_ready low while stalled, all 6 results in order, outputs stable during stall.
REQ-039 Async reset pulse after 2 of 4 mode-1 beats -> out_valid 0 at once, no result; fresh group (5,2,last) -> 10.

Source files
------------

// File: rtl/cnn_core_mac_pkg.sv
// Shared mode encodings, sideband beat tag and saturation bounds for the CNN MAC pipeline.
package cnn_core_mac_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    // Sideband carried alongside each multiplier stage.
    typedef struct packed {
        logic vld;
        logic mode;
        logic last;
    } meta_t;

    // Largest signed value representable in acc_w bits (acc_w <= 64).
    function automatic logic [63:0] sat_max(input int acc_w);
        logic [63:0] v;
        v = 64'd1 << (acc_w - 1);
        return v - 64'd1;
    endfunction

    // Smallest signed value; the low acc_w bits of the result hold -2^(acc_w-1).
    function automatic logic [63:0] sat_min(input int acc_w);
        return ~sat_max(acc_w);
    endfunction

endpackage

// File: rtl/cnn_core_mul_su_pipe.sv
// Signed x unsigned multiplier, product registered NUM_STAGE times.
// Latency: NUM_STAGE cycles from operands to p.
// Backpressure: every stage holds while ce is low.
module cnn_core_mul_su_pipe
    import cnn_core_mac_pkg::*;
#(
    parameter int A_W       = 16,
    parameter int B_W       = 6,
    parameter int NUM_STAGE = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [A_W-1:0]     mul_a,
    input  logic [B_W-1:0]     mul_b,
    output logic [A_W+B_W-1:0] mul_p
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0] prod;
    logic [P_W-1:0] stg_d [NUM_STAGE];
    logic [P_W-1:0] stg_q [NUM_STAGE];

    // Zero-extending mul_b keeps its top bit from being read as a sign; P_W bits
    // always hold the exact product since |a*b| < 2^(P_W-1).
    always_comb begin
        prod     = P_W'($signed(mul_a)) * P_W'($signed({1'b0, mul_b}));
        stg_d[0] = ce ? prod : stg_q[0];
        for (int i = 1; i < NUM_STAGE; i++) begin
            stg_d[i] = ce ? stg_q[i-1] : stg_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                stg_q[i] <= stg_d[i];
            end
        end
    end

    assign mul_p = stg_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_core_mac_pipe.sv
// Pipelined signed x unsigned MAC with per-beat multiply-only or saturating accumulate mode.
// Latency: NUM_STAGE+1 cycles from accepted beat to out_valid; one beat per cycle.
// Backpressure: global stall, in_ready = !out_valid || out_ready; all stages hold when stalled.
module cnn_core_mac_pipe
    import cnn_core_mac_pkg::*;
#(
    parameter int DIN0_W    = 16,
    parameter int DIN1_W    = 6,
    parameter int NUM_STAGE = 3,
    parameter int ACC_W     = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN0_W-1:0] din0,
    input  logic [DIN1_W-1:0] din1,
    input  logic              in_last,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int P_W = DIN0_W + DIN1_W;
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    logic             ce;
    logic [P_W-1:0]   mul_p;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_sat;
    logic             sum_ovf;
    meta_t            tail;

    meta_t meta_d [NUM_STAGE];
    meta_t meta_q [NUM_STAGE];

    logic             out_valid_d, out_valid_q;
    logic [ACC_W-1:0] out_data_d,  out_data_q;
    logic             out_sat_d,   out_sat_q;
    logic [ACC_W-1:0] acc_d,       acc_q;
    logic             grp_open_d,  grp_open_q;
    logic             grp_sat_d,   grp_sat_q;

    assign ce       = !out_valid_q || out_ready;
    assign in_ready = ce;

    cnn_core_mul_su_pipe #(
        .A_W       (DIN0_W),
        .B_W       (DIN1_W),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .ce    (ce),
        .mul_a (din0),
        .mul_b (din1),
        .mul_p (mul_p)
    );

    assign prod_ext = ACC_W'($signed(mul_p));
    assign tail     = meta_q[NUM_STAGE-1];

    always_comb begin
        meta_d[0] = ce ? {in_valid, mode, in_last} : meta_q[0];
        for (int i = 1; i < NUM_STAGE; i++) begin
            meta_d[i] = ce ? meta_q[i-1] : meta_q[i];
        end
    end

    // One guard bit catches signed overflow; the first beat of a group loads instead of adding.
    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        sum_ovf  = grp_open_q && (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
        if (!grp_open_q) begin
            sum_sat = prod_ext;
        end else if (sum_ovf) begin
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_wide[ACC_W-1:0];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        acc_d       = acc_q;
        grp_open_d  = grp_open_q;
        grp_sat_d   = grp_sat_q;
        if (ce) begin
            out_valid_d = 1'b0;
            if (tail.vld) begin
                // A multiply-only beat inside an open group leaves that group untouched.
                if (tail.mode == MODE_MUL) begin
                    out_valid_d = 1'b1;
                    out_data_d  = prod_ext;
                    out_sat_d   = 1'b0;
                end else if (tail.last) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sum_sat;
                    out_sat_d   = grp_sat_q || sum_ovf;
                    acc_d       = '0;
                    grp_open_d  = 1'b0;
                    grp_sat_d   = 1'b0;
                end else begin
                    acc_d       = sum_sat;
                    grp_open_d  = 1'b1;
                    grp_sat_d   = grp_sat_q || sum_ovf;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                meta_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            acc_q       <= '0;
            grp_open_q  <= 1'b0;
            grp_sat_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                meta_q[i] <= meta_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            acc_q       <= acc_d;
            grp_open_q  <= grp_open_d;
            grp_sat_q   <= grp_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
